i2c_regfile: RTL and testbench

- Downstream consumer of the I2C slave receiver. It turns the received byte stream into writes to a small bank of 8-bit configuration registers.
- Bus-frame convention: first byte after START is the register pointer; each later byte is written to the pointed register, then the pointer auto-increments.
- Register contents drive the rest of the design as a flat parallel bus.

---
 rtl/i2c_regfile.sv | 125 ++++++++++++
 tb/tb_i2c_regfile.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_regfile.sv
// i2c_regfile: turns an I2C receiver byte stream (pointer byte, then data bytes) into
// writes to a bank of 8-bit registers. Optional write lock via I2C_REGFILE_LOCK_EN. Rev 1.0
`default_nettype none

module i2c_regfile #(
  parameter int         NUM_REGS  = 8,
  parameter int         PTR_W     = 3,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            data,
  input  logic                  data_valid,
  input  logic                  start,
  input  logic                  stop,
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic                  wr_strobe,
  output logic [PTR_W-1:0]      wr_ptr,
  output logic                  ptr_err,
  output logic                  busy
);

  localparam logic [8:0]       NUM_REGS_W = 9'(NUM_REGS);
  localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GET_PTR = 2'd1,
    WRITE   = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [7:0]       regs [NUM_REGS];
  logic [PTR_W-1:0] ptr;
  logic             dv_q;
  logic             byte_ev;
  logic             locked;
  logic             load_ptr, advance, write_en, set_err;

  assign byte_ev = data_valid & ~dv_q;
  assign busy    = (state != IDLE);

`ifdef I2C_REGFILE_LOCK_EN
  assign locked = regs[NUM_REGS-1][7];
`else
  assign locked = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // start beats stop beats byte_ev; a byte coincident with start/stop is dropped
  always_comb begin
    state_n  = state;
    load_ptr = 1'b0;
    advance  = 1'b0;
    write_en = 1'b0;
    set_err  = 1'b0;
    if (start) begin
      state_n = GET_PTR;
    end else if (stop) begin
      state_n = IDLE;
    end else if (byte_ev) begin
      case (state)
        GET_PTR: begin
          if ({1'b0, data} < NUM_REGS_W) begin
            load_ptr = 1'b1;
            state_n  = WRITE;
          end else begin
            set_err = 1'b1;
            state_n = DISCARD;
          end
        end
        WRITE: begin
          advance  = 1'b1;
          write_en = ~locked | (ptr == LAST_IDX);
        end
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dv_q      <= 1'b0;
      ptr       <= '0;
      ptr_err   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_ptr    <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs[k] <= RESET_VAL;
      end
    end else begin
      dv_q      <= data_valid;
      wr_strobe <= write_en;
      if (set_err) begin
        ptr_err <= 1'b1;
      end
      if (load_ptr) begin
        ptr <= data[PTR_W-1:0];
      end else if (advance) begin
        ptr <= ptr + PTR_W'(1);
      end
      if (write_en) begin
        regs[ptr] <= data;
        wr_ptr    <= ptr;
      end
    end
  end

  generate
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_pack
      assign regs_o[8*k +: 8] = regs[k];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_i2c_regfile.sv
// tb_i2c_regfile: table-driven check of i2c_regfile frames plus hand-written corner sequences.
// Rev 1.0
`default_nettype none

module tb_i2c_regfile;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data = 8'h00;
  logic        data_valid = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [63:0] regs_o;
  logic        wr_strobe;
  logic [2:0]  wr_ptr;
  logic        ptr_err;
  logic        busy;

  int total = 0;
  int bad   = 0;

`ifdef I2C_REGFILE_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  i2c_regfile #(.NUM_REGS(8), .PTR_W(3), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .data(data), .data_valid(data_valid),
    .start(start), .stop(stop), .regs_o(regs_o), .wr_strobe(wr_strobe),
    .wr_ptr(wr_ptr), .ptr_err(ptr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] K_START = 2'd0, K_STOP = 2'd1, K_BYTE = 2'd2;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] val;
    logic       e_stb;
    logic [2:0] e_ptr;
    logic       e_busy;
    logic       e_err;
    int         r_idx;
    logic [7:0] r_val;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] reg_at(input int idx);
    return regs_o[8*idx +: 8];
  endfunction

  task automatic add(input logic [1:0] k, input logic [7:0] v, input logic stb, input logic [2:0] p,
                     input logic b, input logic e, input int ri, input logic [7:0] rv);
    vec_t t;
    t.kind = k; t.val = v; t.e_stb = stb; t.e_ptr = p; t.e_busy = b; t.e_err = e;
    t.r_idx = ri; t.r_val = rv;
    vecs.push_back(t);
  endtask

  // drive one op on the falling edge, sample 1 time unit after the next rising edge
  task automatic apply(input vec_t t, input int n);
    string tag;
    tag = $sformatf("vec%0d", n);
    @(negedge clk);
    case (t.kind)
      K_START: start = 1'b1;
      K_STOP:  stop = 1'b1;
      default: begin data = t.val; data_valid = 1'b1; end
    endcase
    @(posedge clk); #1;
    check({tag, " strobe"}, 32'(wr_strobe), 32'(t.e_stb));
    if (t.e_stb) check({tag, " wr_ptr"}, 32'(wr_ptr), 32'(t.e_ptr));
    check({tag, " busy"}, 32'(busy), 32'(t.e_busy));
    check({tag, " ptr_err"}, 32'(ptr_err), 32'(t.e_err));
    check({tag, " reg"}, 32'(reg_at(t.r_idx)), 32'(t.r_val));
    @(negedge clk);
    start = 1'b0; stop = 1'b0; data_valid = 1'b0;
  endtask

  task automatic pulse(input logic [1:0] k);
    @(negedge clk);
    if (k == K_START) start = 1'b1; else stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic send(input logic [7:0] v);
    @(negedge clk);
    data = v; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  initial begin
    int stb_cnt;

    // frame to reg2/reg3, stray byte in IDLE, wrap 7->0
    add(K_START, 8'h00, 0, 0, 1, 0, 0, 8'h00);
    add(K_BYTE,  8'h02, 0, 0, 1, 0, 2, 8'h00);
    add(K_BYTE,  8'hA5, 1, 2, 1, 0, 2, 8'hA5);
    add(K_BYTE,  8'h3C, 1, 3, 1, 0, 3, 8'h3C);
    add(K_STOP,  8'h00, 0, 0, 0, 0, 2, 8'hA5);
    add(K_BYTE,  8'h77, 0, 0, 0, 0, 4, 8'h00);
    add(K_START, 8'h00, 0, 0, 1, 0, 7, 8'h00);
    add(K_BYTE,  8'h07, 0, 0, 1, 0, 7, 8'h00);
    add(K_BYTE,  8'h11, 1, 7, 1, 0, 7, 8'h11);
    add(K_BYTE,  8'h22, 1, 0, 1, 0, 0, 8'h22);
    add(K_STOP,  8'h00, 0, 0, 0, 0, 1, 8'h00);
    // bad pointer, discard, sticky error across START
    add(K_START, 8'h00, 0, 0, 1, 0, 1, 8'h00);
    add(K_BYTE,  8'h09, 0, 0, 1, 1, 1, 8'h00);
    add(K_BYTE,  8'hFF, 0, 0, 1, 1, 0, 8'h22);
    add(K_START, 8'h00, 0, 0, 1, 1, 7, 8'h11);
    add(K_BYTE,  8'h00, 0, 0, 1, 1, 0, 8'h22);
    add(K_BYTE,  8'h01, 1, 0, 1, 1, 0, 8'h01);
    add(K_STOP,  8'h00, 0, 0, 0, 1, 0, 8'h01);
    // repeated START
    add(K_START, 8'h00, 0, 0, 1, 1, 4, 8'h00);
    add(K_BYTE,  8'h04, 0, 0, 1, 1, 4, 8'h00);
    add(K_BYTE,  8'h10, 1, 4, 1, 1, 4, 8'h10);
    add(K_START, 8'h00, 0, 0, 1, 1, 5, 8'h00);
    add(K_BYTE,  8'h06, 0, 0, 1, 1, 6, 8'h00);
    add(K_BYTE,  8'h20, 1, 6, 1, 1, 6, 8'h20);
    add(K_STOP,  8'h00, 0, 0, 0, 1, 5, 8'h00);
    // lock bit set in reg7, then attempted writes to reg0/reg1, then unlock
    add(K_START, 8'h00, 0, 0, 1, 1, 7, 8'h11);
    add(K_BYTE,  8'h07, 0, 0, 1, 1, 7, 8'h11);
    add(K_BYTE,  8'h80, 1, 7, 1, 1, 7, 8'h80);
    add(K_START, 8'h00, 0, 0, 1, 1, 0, 8'h01);
    add(K_BYTE,  8'h00, 0, 0, 1, 1, 0, 8'h01);
    add(K_BYTE,  8'h33, !LOCK, 0, 1, 1, 0, LOCK ? 8'h01 : 8'h33);
    add(K_BYTE,  8'h44, !LOCK, 1, 1, 1, 1, LOCK ? 8'h00 : 8'h44);
    add(K_START, 8'h00, 0, 0, 1, 1, 7, 8'h80);
    add(K_BYTE,  8'h07, 0, 0, 1, 1, 7, 8'h80);
    add(K_BYTE,  8'h00, 1, 7, 1, 1, 7, 8'h00);
    add(K_START, 8'h00, 0, 0, 1, 1, 0, LOCK ? 8'h01 : 8'h33);
    add(K_BYTE,  8'h00, 0, 0, 1, 1, 0, LOCK ? 8'h01 : 8'h33);
    add(K_BYTE,  8'h33, 1, 0, 1, 1, 0, 8'h33);
    add(K_STOP,  8'h00, 0, 0, 0, 1, 0, 8'h33);

    repeat (2) @(negedge clk);
    #1;
    check("async reset regs", 32'(regs_o == 64'h0), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset strobe", 32'(wr_strobe), 32'd0);
    check("reset wr_ptr", 32'(wr_ptr), 32'd0);
    check("reset ptr_err", 32'(ptr_err), 32'd0);
    check("reset busy", 32'(busy), 32'd0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // one byte held for 20 cycles at pointer 1 produces one write
    pulse(K_START);
    send(8'h01);
    @(negedge clk);
    data = 8'h5A; data_valid = 1'b1;
    stb_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (wr_strobe) stb_cnt++;
    end
    @(negedge clk);
    data_valid = 1'b0;
    @(posedge clk); #1;
    if (wr_strobe) stb_cnt++;
    check("held dv strobes", 32'(stb_cnt), 32'd1);
    check("held dv reg1", 32'(reg_at(1)), 32'h5A);

    // start coincident with a data_valid rise drops that byte
    pulse(K_START);
    send(8'h03);
    @(negedge clk);
    start = 1'b1; data = 8'hEE; data_valid = 1'b1;
    @(posedge clk); #1;
    check("coincident strobe", 32'(wr_strobe), 32'd0);
    check("coincident reg3", 32'(reg_at(3)), 32'h3C);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    data_valid = 1'b0;
    send(8'h05);
    @(negedge clk);
    data = 8'h99; data_valid = 1'b1;
    @(posedge clk); #1;
    check("after drop strobe", 32'(wr_strobe), 32'd1);
    check("after drop wr_ptr", 32'(wr_ptr), 32'd5);
    check("after drop reg5", 32'(reg_at(5)), 32'h99);
    @(negedge clk);
    data_valid = 1'b0;

    // reset mid-frame, then a byte without START is ignored
    pulse(K_START);
    send(8'h02);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midframe regs", 32'(regs_o == 64'h0), 32'd1);
    check("midframe busy", 32'(busy), 32'd0);
    check("midframe ptr_err", 32'(ptr_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    data = 8'h55; data_valid = 1'b1;
    @(posedge clk); #1;
    check("post reset strobe", 32'(wr_strobe), 32'd0);
    check("post reset regs", 32'(regs_o == 64'h0), 32'd1);
    @(negedge clk);
    data_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
